bcd_display_mux: RTL and testbench
==================================

Name: bcd_display_mux

Overview:
- Downstream consumer of a chain of bcd_digit counters.
- Takes the packed BCD counts of NUM_DIGITS digits and time-multiplexes them onto one common 7-segment bus with per-digit enables.
- Provides a snapshot per scan frame (no tearing), a dead-time between digits (no ghosting), leading-zero blanking, and an invalid-code indication.
- Sits between the counter chain and the board display pins.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned; digit 0 is least significant.
SLOT_CLKS, 1000, clocks per digit slot (dead-time plus show); must be greater than BLANK_CLKS.
BLANK_CLKS, 50, clocks at the start of each slot during which all digits are off; must be at least 1.
SEG_ACTIVE_LOW, 1, 1 means segment pins are driven low to light.
DIG_ACTIVE_LOW, 1, 1 means digit-select pins are driven low to enable.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
sys_reset  in  1  synchronous reset, active-low.
counts  in  4*NUM_DIGITS  packed BCD digits; digit k is counts[4k+3:4k].
lz_blank  in  1  1 enables leading-zero blanking.
seg  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
digit_sel  out  NUM_DIGITS  one-hot digit enable, polarity set by DIG_ACTIVE_LOW.
frame_tick  out  1  one-cycle pulse on the last clock of each full frame.

Behaviour:
- Reset: sys_reset low at a clock edge sets the following.
  - All outputs register to their inactive level: seg all off, digit_sel all off, frame_tick=0.
  - FSM goes to BLANK, digit index idx=0, slot timer=0, snapshot=0.
  - Reset asserted mid-frame aborts the scan immediately on that edge.
- Snapshot:
  - counts are captured into the snapshot register on every cycle where the FSM enters BLANK with idx=0. This includes the first cycle after reset release.
  - Changes to counts within a frame have no visible effect until the next frame.
- FSM states are BLANK and SHOW. The timer counts 0..SLOT_CLKS-1 within each slot.
  - BLANK: digit_sel all off, seg all off. When timer = BLANK_CLKS-1, go to SHOW.
  - SHOW: the enable bit for idx is active; seg = decoded snapshot digit idx. When timer = SLOT_CLKS-1:
    - timer resets to 0, FSM goes to BLANK;
    - idx increments, wrapping NUM_DIGITS-1 to 0;
    - frame_tick=1 for that one cycle if idx was NUM_DIGITS-1.
- Output timing:
  - Outputs are registered; they reflect state one clock after the state transition.
  - Digit k is lit for exactly SLOT_CLKS-BLANK_CLKS consecutive clocks per frame.
  - Frame period is NUM_DIGITS*SLOT_CLKS clocks.
- Decode:
  - Digits 0-9 use standard 7-segment glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F (active-high, {g..a}).
  - Codes 10-15 display a dash (0x40).
- Leading-zero blanking:
  - Applies when lz_blank=1.
  - Digit k>0 is blanked (seg off, digit_sel still active) if snapshot digits k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - An invalid code counts as nonzero.
  - lz_blank is sampled together with the snapshot.
- Polarity: inversion per parameter is applied at the output register. The internal logic is active-high throughout.

Decomposition:
- Package bcd_display_pkg holds:
  - segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - the FSM state encoding (ST_BLANK, ST_SHOW).
- One sub-module, bcd_to_7seg: purely combinational, 4-bit BCD in, 7-bit active-high segments out, dash for codes 10-15.
- The timer, FSM, snapshot and blanking logic stay in bcd_display_mux.

Test Plan:
All scenarios use NUM_DIGITS=4, SLOT_CLKS=8, BLANK_CLKS=2, both polarities active-low.
1. Reset, then counts=0x1234, lz_blank=0.
   - Digit 0 is active for 6 clocks with seg=~0x66, then 2 clocks all off; digits 1, 2, 3 follow with ~0x4F, ~0x5B, ~0x06.
   - frame_tick pulses once every 32 clocks.
2. counts=0x0050, lz_blank=1.
   - Digits 3 and 2 show seg=0x7F (off) while their digit_sel is active; digit 1 shows ~0x6D; digit 0 shows ~0x3F.
   - With counts=0x0000, only digit 0 lights, showing ~0x3F.
3. counts=0x00A7, lz_blank=1 → digit 1 shows a dash (~0x40); digits 3 and 2 are blank; digit 0 shows ~0x07.
4. counts changes from 0x1111 to 0x9999 mid-frame (during digit 1's slot).
   - The remaining digits of that frame still show ~0x06.
   - The next frame shows ~0x6F on all digits.
5. sys_reset driven low for 1 cycle during digit 2 SHOW.
   - The next edge gives all-off outputs and frame_tick=0.
   - After release, the scan restarts at digit 0 with BLANK and a fresh snapshot.
6. Drive counts from a bcd_digit chain ticked 15 times → digit 0 displays 5 (~0x6D) and digit 1 displays 1 (~0x06).

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants for the multiplexed BCD 7-segment display driver.
package bcd_display_pkg;

  // Active-high segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Scan FSM encoding
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; codes 10-15 show a dash.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  // Glyph lookup
  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Time-multiplexed BCD display scanner: per-frame snapshot, dead-time between
// digits, leading-zero blanking and registered, polarity-adjusted pin outputs.
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SLOT_CLKS      = 1000,
  parameter int unsigned BLANK_CLKS     = 50,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset,
  input  logic [4*NUM_DIGITS-1:0] counts,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TMR_W = $clog2(SLOT_CLKS);

  logic [0:0]            state, state_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]      snap;
  logic                  snap_lz;
  logic                  snap_load;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            glyph;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] dsel_nxt;
  logic                  tick_nxt;

  // Digit k>0 is suppressed when it and every more significant digit are zero
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run   = zero_run & (snap[4*k +: 4] == 4'd0);
      lz_mask[k] = snap_lz & zero_run & (k != 0);
    end
  end

  // Select the snapshot nibble and blank flag for the digit being scanned
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = snap[4*k +: 4];
        cur_blank = lz_mask[k];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd   (cur_digit),
    .seg_c (glyph)
  );

  // Next-state, slot timing and active-high output values
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + TMR_W'(1);
    idx_nxt   = idx;
    seg_nxt   = SEG_OFF;
    dsel_nxt  = '0;
    tick_nxt  = 1'b0;
    snap_load = (state == ST_BLANK) && (idx == '0) && (timer == '0);
    case (state)
      ST_BLANK: begin
        if (timer == TMR_W'(BLANK_CLKS - 1)) begin
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        seg_nxt  = cur_blank ? SEG_OFF : glyph;
        dsel_nxt = NUM_DIGITS'(1) << idx;
        if (timer == TMR_W'(SLOT_CLKS - 1)) begin
          state_nxt = ST_BLANK;
          timer_nxt = '0;
          if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt  = '0;
            tick_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        timer_nxt = '0;
      end
    endcase
  end

  // State, snapshot and polarity-adjusted output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state      <= ST_BLANK;
      timer      <= '0;
      idx        <= '0;
      snap       <= '0;
      snap_lz    <= 1'b0;
      seg        <= {7{SEG_ACTIVE_LOW}} ^ SEG_OFF;
      digit_sel  <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      if (snap_load) begin
        snap    <= counts;
        snap_lz <= lz_blank;
      end
      seg        <= {7{SEG_ACTIVE_LOW}} ^ seg_nxt;
      digit_sel  <= {NUM_DIGITS{DIG_ACTIVE_LOW}} ^ dsel_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux with a frame-position reference model.
module tb_bcd_display_mux;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = ND * SLOT;

  logic          clk;
  logic          sys_reset;
  logic [15:0]   counts;
  logic          lz_blank;
  logic [6:0]    seg;
  logic [3:0]    digit_sel;
  logic          frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_display_mux #(
    .NUM_DIGITS(ND), .SLOT_CLKS(SLOT), .BLANK_CLKS(BLNK),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (clk),
    .sys_reset  (sys_reset),
    .counts     (counts),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Active-high glyph table indexed by BCD code
  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return tbl[d];
  endfunction

  // Reference model: position in frame from edges since reset release
  int          m_n = -1;
  bit          m_valid = 0;
  logic [15:0] m_snap;
  logic        m_lz;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dsel;
  logic        exp_tick;

  task automatic model_step();
    int p, k, w;
    logic blank;
    if (!sys_reset) begin
      m_n = -1;
      m_snap = '0;
      m_lz = 1'b0;
      exp_seg = 7'h7F; exp_dsel = 4'hF; exp_tick = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      m_n++;
      p = m_n % FRAME;
      if (p == 0) begin
        m_snap = counts;
        m_lz = lz_blank;
      end
      k = p / SLOT;
      w = p % SLOT;
      exp_tick = (p == FRAME - 1);
      if (w >= BLNK) begin
        blank = m_lz && (k > 0) && ((m_snap >> (4 * k)) == 16'd0);
        exp_dsel = ~(4'b0001 << k);
        exp_seg  = blank ? 7'h7F : ~glyph_of(4'((m_snap >> (4 * k)) & 16'hF));
      end else begin
        exp_dsel = 4'hF;
        exp_seg  = 7'h7F;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_seg", 16'(seg), 16'(exp_seg));
      check("model_digit_sel", 16'(digit_sel), 16'(exp_dsel));
      check("model_frame_tick", 16'(frame_tick), 16'(exp_tick));
    end
  end

  // Driver-side cycle index: value of m_n that the current outputs reflect
  int ncy;

  task automatic step();
    @(negedge clk);
    ncy++;
  endtask

  task automatic go_to(input int target);
    while (ncy < target) step();
  endtask

  task automatic lit(input string name, input logic [6:0] s, input logic [3:0] d);
    check({name, "_seg"}, 16'(seg), 16'(s));
    check({name, "_dsel"}, 16'(digit_sel), 16'(d));
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  initial begin
    logic [15:0] chain;
    sys_reset = 1'b0;
    counts    = 16'h1234;
    lz_blank  = 1'b0;
    ncy = 0;
    repeat (3) @(negedge clk);
    lit("reset", 7'h7F, 4'hF);
    check("reset_tick", 16'(frame_tick), 16'd0);
    sys_reset = 1'b1;
    ncy = -1;

    // Scenario 1: plain scan of 0x1234
    go_to(1);  lit("s1_blank", 7'h7F, 4'hF);
    go_to(4);  lit("s1_d0", 7'h19, 4'b1110);
    go_to(7);  lit("s1_d0_last", 7'h19, 4'b1110);
    go_to(8);  lit("s1_dead", 7'h7F, 4'hF);
    go_to(12); lit("s1_d1", 7'h30, 4'b1101);
    go_to(20); lit("s1_d2", 7'h24, 4'b1011);
    go_to(28); lit("s1_d3", 7'h79, 4'b0111);
    go_to(31); check("s1_tick", 16'(frame_tick), 16'd1);
    go_to(32); check("s1_tick_end", 16'(frame_tick), 16'd0);
    go_to(63); check("s1_tick2", 16'(frame_tick), 16'd1);

    // Scenario 2: leading-zero blanking
    counts = 16'h0050; lz_blank = 1'b1;
    go_to(68); lit("s2_d0", 7'h40, 4'b1110);
    go_to(76); lit("s2_d1", 7'h12, 4'b1101);
    go_to(84); lit("s2_d2", 7'h7F, 4'b1011);
    go_to(92); lit("s2_d3", 7'h7F, 4'b0111);
    go_to(95); counts = 16'h0000;
    go_to(100); lit("s2z_d0", 7'h40, 4'b1110);
    go_to(108); lit("s2z_d1", 7'h7F, 4'b1101);

    // Scenario 3: invalid code counts as nonzero
    go_to(127); counts = 16'h00A7;
    go_to(132); lit("s3_d0", 7'h78, 4'b1110);
    go_to(140); lit("s3_d1", 7'h3F, 4'b1101);
    go_to(148); lit("s3_d2", 7'h7F, 4'b1011);

    // Scenario 4: mid-frame change is deferred to the next frame
    go_to(159); counts = 16'h1111; lz_blank = 1'b0;
    go_to(170); counts = 16'h9999;
    go_to(180); lit("s4_d2", 7'h79, 4'b1011);
    go_to(188); lit("s4_d3", 7'h79, 4'b0111);
    go_to(196); lit("s4_next_d0", 7'h10, 4'b1110);

    // Scenario 5: reset during digit 2 SHOW
    go_to(244); lit("s5_before", 7'h10, 4'b1011);
    sys_reset = 1'b0; counts = 16'h0042;
    step();
    lit("s5_reset", 7'h7F, 4'hF);
    check("s5_reset_tick", 16'(frame_tick), 16'd0);
    sys_reset = 1'b1;
    ncy = -1;
    go_to(1); lit("s5_restart_blank", 7'h7F, 4'hF);
    go_to(4); lit("s5_restart_d0", 7'h5B ^ 7'h7F, 4'b1110);
    go_to(12); lit("s5_restart_d1", 7'h66 ^ 7'h7F, 4'b1101);

    // Scenario 6: counts from a BCD counter chain ticked 15 times
    chain = 16'h0000;
    for (int i = 0; i < 15; i++) chain = bcd_inc(chain);
    go_to(31); counts = chain; lz_blank = 1'b0;
    go_to(36); lit("s6_d0", 7'h12, 4'b1110);
    go_to(44); lit("s6_d1", 7'h79, 4'b1101);

    // Randomized traffic, including invalid codes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) begin
        counts   = 16'($urandom);
        lz_blank = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) == 1) counts[4*k +: 4] = 4'd0;
      end
      if ($urandom_range(0, 599) == 0) begin
        sys_reset = 1'b0;
        step();
        sys_reset = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
